// File: rtl/idu_pkg.sv
// Shared decode definitions for the instruction decode stage (idu).
// Holds opcode constants, immediate-format and ALU-op encodings, the FSM
// state constants and small decode helper functions.
package idu_pkg;

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // The only two SYSTEM words this stage treats as legal
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_t;

    // Pipeline-register occupancy: IDLE holds nothing, FULL holds one bundle
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t FULL = 1'b1;

    // ALU op from funct3; alt is inst[30]. SUB only exists for register-register ops,
    // while SRA/SRL is selected by inst[30] for both OP and OP-IMM.
    function automatic alu_op_t alu_from_funct(input logic [2:0] f3, input logic alt,
                                               input logic allow_sub);
        alu_op_t op;
        case (f3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Which register fields an opcode actually reads/writes: {rd, rs1, rs2}
    function automatic logic [2:0] reg_use(input logic [6:0] opcode);
        logic [2:0] u;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: u = 3'b100;
            OP_JALR, OP_LOAD, OP_IMM: u = 3'b110;
            OP_BRANCH, OP_STORE:      u = 3'b011;
            OP_OP:                    u = 3'b111;
            default:                  u = 3'b000;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/idu_imm_gen.sv
// Immediate generator for the decode stage: selects and sign-extends the
// immediate field of a 32-bit RV32I word according to its format.
module idu_imm_gen
    import idu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  imm_type_t       imm_type,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Assemble the 32-bit immediate for the requested format
    always_comb begin
        imm32 = 32'h0;
        case (imm_type)
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = 32'h0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/idu.sv
// Instruction decode stage (idu). Consumes {pc, inst} from IFU, decodes RV32I
// and offers a registered control/operand bundle to EXU. One-entry pipeline
// register, zero-bubble: a held bundle can drain and be replaced in one cycle.
//
// Handshake: on both links a transfer happens on a rising edge where valid and
// ready are both 1; valid is held with stable data until it transfers, and
// ready_out_ifu depends combinationally on ready_in_exu.
//
// Build option: define IDU_RV32E_EN to restrict register fields to x0-x15;
// any used rd/rs1/rs2 with bit 4 set is then flagged illegal.
module idu
    import idu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in_ifu,
    output logic              ready_out_ifu,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [31:0]       inst_in,
    output logic              valid_out_exu,
    input  logic              ready_in_exu,
    output logic [XLEN-1:0]   pc_out,
    output logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [XLEN-1:0]   imm,
    output logic [2:0]        funct3,
    output alu_op_t           alu_op,
    output logic              reg_wen,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic              branch,
    output logic              jal,
    output logic              jalr,
    output logic              ebreak,
    output logic              illegal
);

    state_t state;
    logic   accept;

    logic [6:0]      opcode;
    imm_type_t       d_imm_type;
    logic [XLEN-1:0] d_imm;
    alu_op_t         d_alu_op;
    logic            d_reg_wen, d_mem_ren, d_mem_wen, d_branch, d_jal, d_jalr;
    logic            d_ebreak, d_illegal, d_bad_reg;

    assign opcode        = inst_in[6:0];
    assign ready_out_ifu = (state == IDLE) | ready_in_exu;
    assign valid_out_exu = (state == FULL);
    assign accept        = valid_in_ifu & ready_out_ifu;

`ifdef IDU_RV32E_EN
    logic [2:0] uses;
    assign uses      = reg_use(opcode);
    assign d_bad_reg = (uses[2] & inst_in[11]) | (uses[1] & inst_in[19]) | (uses[0] & inst_in[24]);
`else
    assign d_bad_reg = 1'b0;
`endif

    idu_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst     (inst_in),
        .imm_type (d_imm_type),
        .imm      (d_imm)
    );

    // Combinational decode of the offered word into control flags
    always_comb begin
        d_imm_type = IMM_NONE;
        d_alu_op   = ALU_ADD;
        d_reg_wen  = 1'b0;
        d_mem_ren  = 1'b0;
        d_mem_wen  = 1'b0;
        d_branch   = 1'b0;
        d_jal      = 1'b0;
        d_jalr     = 1'b0;
        d_ebreak   = 1'b0;
        d_illegal  = 1'b0;
        case (opcode)
            OP_LUI: begin
                d_imm_type = IMM_U;
                d_alu_op   = ALU_PASS_B;
                d_reg_wen  = 1'b1;
            end
            OP_AUIPC: begin
                d_imm_type = IMM_U;
                d_reg_wen  = 1'b1;
            end
            OP_JAL: begin
                d_imm_type = IMM_J;
                d_reg_wen  = 1'b1;
                d_jal      = 1'b1;
            end
            OP_JALR: begin
                d_imm_type = IMM_I;
                d_reg_wen  = 1'b1;
                d_jalr     = 1'b1;
            end
            OP_BRANCH: begin
                d_imm_type = IMM_B;
                d_alu_op   = ALU_SUB;
                d_branch   = 1'b1;
            end
            OP_LOAD: begin
                d_imm_type = IMM_I;
                d_reg_wen  = 1'b1;
                d_mem_ren  = 1'b1;
            end
            OP_STORE: begin
                d_imm_type = IMM_S;
                d_mem_wen  = 1'b1;
            end
            OP_IMM: begin
                d_imm_type = IMM_I;
                d_alu_op   = alu_from_funct(inst_in[14:12], inst_in[30], 1'b0);
                d_reg_wen  = 1'b1;
            end
            OP_OP: begin
                d_alu_op   = alu_from_funct(inst_in[14:12], inst_in[30], 1'b1);
                d_reg_wen  = 1'b1;
            end
            OP_SYSTEM: begin
                d_imm_type = IMM_I;
                if (inst_in == INST_EBREAK) begin
                    d_ebreak = 1'b1;
                end else if (inst_in != INST_ECALL) begin
                    d_illegal = 1'b1;
                end
            end
            default: d_illegal = 1'b1;
        endcase

        if (d_bad_reg) begin
            d_illegal = 1'b1;
        end
        // Illegal words still travel downstream, but must not cause side effects
        if (d_illegal) begin
            d_reg_wen = 1'b0;
            d_mem_ren = 1'b0;
            d_mem_wen = 1'b0;
            d_branch  = 1'b0;
            d_jal     = 1'b0;
            d_jalr    = 1'b0;
        end
        if (inst_in[11:7] == 5'd0) begin
            d_reg_wen = 1'b0;
        end
    end

    // Occupancy FSM: fill on accept, empty on drain without a replacement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (accept) begin
            state <= FULL;
        end else if (valid_out_exu && ready_in_exu) begin
            state <= IDLE;
        end
    end

    // Bundle register: loads on accept, otherwise holds bit-stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out  <= '0;
            rd      <= '0;
            rs1     <= '0;
            rs2     <= '0;
            imm     <= '0;
            funct3  <= '0;
            alu_op  <= ALU_ADD;
            reg_wen <= 1'b0;
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            branch  <= 1'b0;
            jal     <= 1'b0;
            jalr    <= 1'b0;
            ebreak  <= 1'b0;
            illegal <= 1'b0;
        end else if (accept) begin
            pc_out  <= pc_in;
            rd      <= REG_AW'(inst_in[11:7]);
            rs1     <= REG_AW'(inst_in[19:15]);
            rs2     <= REG_AW'(inst_in[24:20]);
            imm     <= d_imm;
            funct3  <= inst_in[14:12];
            alu_op  <= d_alu_op;
            reg_wen <= d_reg_wen;
            mem_ren <= d_mem_ren;
            mem_wen <= d_mem_wen;
            branch  <= d_branch;
            jal     <= d_jal;
            jalr    <= d_jalr;
            ebreak  <= d_ebreak;
            illegal <= d_illegal;
        end
    end

endmodule

// File: tb/tb_idu.sv
// Directed testbench for idu: one task per scenario, inline checks, summary line.
module tb_idu;
    import idu_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_in_ifu;
    logic        ready_out_ifu;
    logic [31:0] pc_in;
    logic [31:0] inst_in;
    logic        valid_out_exu;
    logic        ready_in_exu;
    logic [31:0] pc_out;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [2:0]  funct3;
    alu_op_t     alu_op;
    logic        reg_wen, mem_ren, mem_wen, branch, jal, jalr, ebreak, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    idu dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in_ifu  (valid_in_ifu),
        .ready_out_ifu (ready_out_ifu),
        .pc_in         (pc_in),
        .inst_in       (inst_in),
        .valid_out_exu (valid_out_exu),
        .ready_in_exu  (ready_in_exu),
        .pc_out        (pc_out),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .imm           (imm),
        .funct3        (funct3),
        .alu_op        (alu_op),
        .reg_wen       (reg_wen),
        .mem_ren       (mem_ren),
        .mem_wen       (mem_wen),
        .branch        (branch),
        .jal           (jal),
        .jalr          (jalr),
        .ebreak        (ebreak),
        .illegal       (illegal)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction with EXU ready; it is accepted at the next edge
    task automatic drive_one(input logic [31:0] pc, input logic [31:0] inst);
        pc_in        = pc;
        inst_in      = inst;
        valid_in_ifu = 1'b1;
        ready_in_exu = 1'b1;
        step();
        valid_in_ifu = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in_ifu = 1'b0; ready_in_exu = 1'b0; pc_in = '0; inst_in = '0;
        step(); step();
        n_tests++; if (valid_out_exu !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid_out_exu); end
        n_tests++; if ({pc_out, imm, rd, rs1, rs2, funct3} !== '0) begin n_fail++; $display("FAIL reset_bundle got pc=%h imm=%h rd=%0d exp 0", pc_out, imm, rd); end
        n_tests++; if ({reg_wen, mem_ren, mem_wen, branch, jal, jalr, ebreak, illegal} !== 8'h0) begin n_fail++; $display("FAIL reset_flags got nonzero flags exp 0"); end
        n_tests++; if (ready_out_ifu !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready_out_ifu); end
        rst = 1'b0;
        step();
        n_tests++; if (valid_out_exu !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got %b exp 0", valid_out_exu); end
    endtask

    task automatic test_addi();
        drive_one(32'h8000_0000, 32'h0050_0093);
        n_tests++; if (valid_out_exu !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b exp 1", valid_out_exu); end
        n_tests++; if (rd !== 5'd1 || rs1 !== 5'd0) begin n_fail++; $display("FAIL addi_regs got rd=%0d rs1=%0d exp rd=1 rs1=0", rd, rs1); end
        n_tests++; if (imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm got %h exp 5", imm); end
        n_tests++; if (reg_wen !== 1'b1 || illegal !== 1'b0) begin n_fail++; $display("FAIL addi_flags got wen=%b ill=%b exp wen=1 ill=0", reg_wen, illegal); end
        n_tests++; if (pc_out !== 32'h8000_0000) begin n_fail++; $display("FAIL addi_pc got %h exp 80000000", pc_out); end
        n_tests++; if (alu_op !== ALU_ADD) begin n_fail++; $display("FAIL addi_alu got %0d exp %0d", alu_op, ALU_ADD); end
        step();
        n_tests++; if (valid_out_exu !== 1'b0) begin n_fail++; $display("FAIL addi_drain got %b exp 0", valid_out_exu); end
    endtask

    task automatic test_stall();
        drive_one(32'h0000_0100, 32'h0050_0093);
        // Offer sub x2,x1,x2 while EXU is stalled
        ready_in_exu = 1'b0; valid_in_ifu = 1'b1; pc_in = 32'h0000_0104; inst_in = 32'h4020_8133;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++; if (ready_out_ifu !== 1'b0) begin n_fail++; $display("FAIL stall_ready c=%0d got %b exp 0", c, ready_out_ifu); end
            n_tests++; if (valid_out_exu !== 1'b1 || pc_out !== 32'h100 || imm !== 32'd5 || rd !== 5'd1 || reg_wen !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold c=%0d got v=%b pc=%h imm=%h rd=%0d exp v=1 pc=100 imm=5 rd=1", c, valid_out_exu, pc_out, imm, rd);
            end
        end
        ready_in_exu = 1'b1;
        #1;
        n_tests++; if (ready_out_ifu !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %b exp 1", ready_out_ifu); end
        step();
        valid_in_ifu = 1'b0;
        n_tests++; if (valid_out_exu !== 1'b1 || pc_out !== 32'h104) begin n_fail++; $display("FAIL stall_new_pc got v=%b pc=%h exp v=1 pc=104", valid_out_exu, pc_out); end
        n_tests++; if (rd !== 5'd2 || rs1 !== 5'd1 || rs2 !== 5'd2 || alu_op !== ALU_SUB || imm !== 32'd0) begin
            n_fail++; $display("FAIL stall_new_sub got rd=%0d rs1=%0d rs2=%0d alu=%0d imm=%h exp 2 1 2 %0d 0", rd, rs1, rs2, alu_op, ALU_SUB, imm);
        end
        step();
    endtask

    task automatic test_back_to_back();
        ready_in_exu = 1'b1;
        valid_in_ifu = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            pc_in   = 32'h200 + 32'(4 * k);
            inst_in = (32'(k) << 20) | 32'h0000_0093;
            step();
            n_tests++; if (valid_out_exu !== 1'b1 || imm !== 32'(k) || pc_out !== 32'h200 + 32'(4 * k)) begin
                n_fail++; $display("FAIL b2b k=%0d got v=%b imm=%h pc=%h exp v=1 imm=%h pc=%h", k, valid_out_exu, imm, pc_out, 32'(k), 32'h200 + 32'(4 * k));
            end
        end
        valid_in_ifu = 1'b0;
        step();
        n_tests++; if (valid_out_exu !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", valid_out_exu); end
    endtask

    task automatic test_formats();
        drive_one(32'h300, 32'hFE00_0EE3);  // beq x0,x0,-4
        n_tests++; if (imm !== 32'hFFFF_FFFC || branch !== 1'b1 || reg_wen !== 1'b0) begin
            n_fail++; $display("FAIL beq got imm=%h br=%b wen=%b exp fffffffc 1 0", imm, branch, reg_wen);
        end
        drive_one(32'h304, 32'h0020_A423);  // sw x2,8(x1)
        n_tests++; if (imm !== 32'd8 || mem_wen !== 1'b1 || reg_wen !== 1'b0 || funct3 !== 3'b010) begin
            n_fail++; $display("FAIL sw got imm=%h mwen=%b wen=%b f3=%b exp 8 1 0 010", imm, mem_wen, reg_wen, funct3);
        end
        drive_one(32'h308, 32'hFFF0_A183);  // lw x3,-1(x1)
        n_tests++; if (imm !== 32'hFFFF_FFFF || mem_ren !== 1'b1 || reg_wen !== 1'b1 || rd !== 5'd3) begin
            n_fail++; $display("FAIL lw got imm=%h mren=%b wen=%b rd=%0d exp ffffffff 1 1 3", imm, mem_ren, reg_wen, rd);
        end
        drive_one(32'h30C, 32'h1234_52B7);  // lui x5,0x12345
        n_tests++; if (imm !== 32'h1234_5000 || rd !== 5'd5 || reg_wen !== 1'b1 || alu_op !== ALU_PASS_B) begin
            n_fail++; $display("FAIL lui got imm=%h rd=%0d wen=%b alu=%0d exp 12345000 5 1 %0d", imm, rd, reg_wen, alu_op, ALU_PASS_B);
        end
        drive_one(32'h310, 32'h0080_00EF);  // jal x1,8
        n_tests++; if (imm !== 32'd8 || jal !== 1'b1 || reg_wen !== 1'b1 || jalr !== 1'b0) begin
            n_fail++; $display("FAIL jal got imm=%h jal=%b wen=%b jalr=%b exp 8 1 1 0", imm, jal, reg_wen, jalr);
        end
        ready_in_exu = 1'b1;
        step();
    endtask

    task automatic test_system();
        drive_one(32'h400, 32'h0010_0073);
        n_tests++; if (ebreak !== 1'b1 || illegal !== 1'b0) begin n_fail++; $display("FAIL ebreak got eb=%b ill=%b exp 1 0", ebreak, illegal); end
        drive_one(32'h404, 32'h0000_0073);
        n_tests++; if (ebreak !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL ecall got eb=%b ill=%b exp 0 0", ebreak, illegal); end
        drive_one(32'h408, 32'h0000_007F);
        n_tests++; if (illegal !== 1'b1 || {reg_wen, mem_ren, mem_wen, branch, jal, jalr} !== 6'b0 || valid_out_exu !== 1'b1) begin
            n_fail++; $display("FAIL illegal_7f got ill=%b v=%b flags=%b exp ill=1 v=1 flags=000000", illegal, valid_out_exu, {reg_wen, mem_ren, mem_wen, branch, jal, jalr});
        end
        drive_one(32'h40C, 32'h0000_0FFF);  // unknown opcode with rd=31
        n_tests++; if (illegal !== 1'b1 || reg_wen !== 1'b0 || rd !== 5'd31) begin
            n_fail++; $display("FAIL illegal_rd31 got ill=%b wen=%b rd=%0d exp 1 0 31", illegal, reg_wen, rd);
        end
        drive_one(32'h410, 32'h0010_1073);  // csrrw-like SYSTEM word, not ebreak/ecall
        n_tests++; if (illegal !== 1'b1 || ebreak !== 1'b0) begin n_fail++; $display("FAIL illegal_sys got ill=%b eb=%b exp 1 0", illegal, ebreak); end
        step();
    endtask

    task automatic test_async_reset();
        drive_one(32'h500, 32'h0050_0093);
        ready_in_exu = 1'b0;
        n_tests++; if (valid_out_exu !== 1'b1) begin n_fail++; $display("FAIL arst_pre got %b exp 1", valid_out_exu); end
        rst = 1'b1;
        #1;
        n_tests++; if (valid_out_exu !== 1'b0 || pc_out !== 32'h0 || rd !== 5'd0 || reg_wen !== 1'b0) begin
            n_fail++; $display("FAIL arst_now got v=%b pc=%h rd=%0d wen=%b exp 0 0 0 0", valid_out_exu, pc_out, rd, reg_wen);
        end
        step();
        rst = 1'b0;
        ready_in_exu = 1'b1;
        step(); step();
        n_tests++; if (valid_out_exu !== 1'b0) begin n_fail++; $display("FAIL arst_release got %b exp 0", valid_out_exu); end
    endtask

    task automatic test_rv32e();
        drive_one(32'h600, 32'h0010_0813);  // addi x16,x0,1
`ifdef IDU_RV32E_EN
        n_tests++; if (illegal !== 1'b1 || reg_wen !== 1'b0) begin n_fail++; $display("FAIL rv32e_x16 got ill=%b wen=%b exp 1 0", illegal, reg_wen); end
`else
        n_tests++; if (rd !== 5'd16 || reg_wen !== 1'b1 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL rv32i_x16 got rd=%0d wen=%b ill=%b exp 16 1 0", rd, reg_wen, illegal);
        end
`endif
        step();
    endtask

    // Main sequence
    initial begin
        test_reset();
        test_addi();
        test_stall();
        test_back_to_back();
        test_formats();
        test_system();
        test_async_reset();
        test_rv32e();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "timeout");
    end

endmodule
